unaligned_store_unit: RTL and testbench
=======================================

Name: unaligned_store_unit

Overview:
- Write-side companion to the instruction/data word memory read path. Performs big-endian, byte-addressed stores of byte, halfword or word size into a word-organised synchronous RAM.
- Unaligned and partial stores use read-modify-write, spanning two adjacent words when needed.
- Sits between the MEM stage store request and the RAM write port. It is also used by the program loader.

Parameters:
- ADDR_W, 10, word-address width of the RAM (2^ADDR_W words of 32 bits).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  store request valid.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_addr  input  32  byte address; only bits [ADDR_W+1:0] used.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_data  input  32  store data, right-justified (byte = [7:0], half = [15:0]).
- done  output  1  one-cycle pulse when store is complete.
- mem_addr  output  ADDR_W  RAM word address.
- mem_ren  output  1  RAM read enable; mem_rdata is valid the following cycle.
- mem_wen  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data (1-cycle synchronous latency).

Behaviour:
- Byte order is big-endian: byte at offset 0 of a word is bits [31:24].
- Accept: a request is taken when req_valid & req_ready at a clock edge (cycle T). addr, size and data are latched. Requests offered while not ready are ignored; the unit does not buffer them.
- Lane computation, with o = addr[1:0]:
  - data_l = data left-justified (byte <<24, half <<16); mask_l = FF000000 / FFFF0000 / FFFFFFFF.
  - win = {data_l,32'b0} >> 8*o; msk = {mask_l,32'b0} >> 8*o (64 bits each).
  - Word w0 = addr[ADDR_W+1:2] uses the upper halves of win/msk.
  - Word w1 = w0+1 (mod 2^ADDR_W, wraps to 0) uses the lower halves.
  - The store spans two words iff the lower half of msk != 0.
  - Merged word = (rdata & ~msk_half) | (win_half & msk_half).
- FSM states: IDLE, RD0, WR0, RD1, WR1, DONE.
  - IDLE: req_ready=1. On accept, go to WR0 if the upper half of msk is all ones (aligned word store, no read); otherwise go to RD0.
  - RD0: mem_addr=w0, mem_ren=1, then WR0.
  - WR0: mem_addr=w0, mem_wen=1, mem_wdata=merged (or data directly when no read was done). Next state is RD1 if spanning, else DONE.
  - RD1: mem_addr=w1, mem_ren=1, then WR1.
  - WR1: mem_addr=w1, mem_wen=1, mem_wdata=merged, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency from accept cycle T to done:
  - aligned word: T+2;
  - non-spanning RMW: T+3;
  - spanning: T+5.
- Next accept is possible at done+1.
- Outputs are combinational from state and latched request.
  - mem_ren and mem_wen are never high together.
  - mem_addr, mem_wdata = 0 in IDLE and DONE.
- Reset: when rst is high at an edge, state = IDLE and the latched request is cleared.
  - During reset: req_ready=0, done=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts the store. Writes already issued stay in RAM; no further writes occur and done is not pulsed.
  - req_ready returns to 1 in the first cycle after rst deasserts.
- Address bits above ADDR_W+1 are ignored (modulo wrap).

Test Plan:
- RAM init w0=0x11223344, w1=0x55667788. Word store, addr 0, data 0xAABBCCDD -> single write w0=0xAABBCCDD; no mem_ren; done at T+2.
- Word store, addr 1, data 0xAABBCCDD -> reads w0 then w1. w0=0x11AABBCC, w1=0xDD667788; done at T+5.
- Byte store, addr 6, data 0x000000EE -> one RMW, w1=0x5566EE88, w0 unchanged; done at T+3.
- Half store, addr 3, data 0x0000BEEF -> w0=0x112233BE, w1=0xEF667788 (spanning).
- Wrap with ADDR_W=10: word 1023=0x00000000, word 0=0x11223344. Word store, addr 0xFFE, data 0xCAFEF00D -> word1023=0x0000CAFE, word0=0xF00D3344.
- Repeat the addr-1 store with rst pulsed during RD1 -> w0=0x11AABBCC, w1 stays 0x55667788, no done. A request held valid during DONE is accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/unaligned_store_unit_if.sv
// Store request and RAM write-port bundle for unaligned_store_unit.
// The unit takes the slave side; the requester/RAM model takes the master side.
interface unaligned_store_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_data;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_rdata,
    output req_ready, done, mem_addr, mem_ren, mem_wen, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_rdata,
    input  req_ready, done, mem_addr, mem_ren, mem_wen, mem_wdata
  );
endinterface

// File: rtl/unaligned_store_unit.sv
// Big-endian byte/half/word store into a word RAM, using read-modify-write
// and spilling into the following word when the store crosses a boundary.
module unaligned_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  unaligned_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;

  logic              accept;
  logic              req_aligned_word;
  logic [31:0]       data_l, mask_l;
  logic [63:0]       win, msk;
  logic [ADDR_W-1:0] w0, w1;
  logic              spanning;
  logic              word_aligned;
  logic [31:0]       merged0, merged1;

  assign accept = bus.req_valid & bus.req_ready;

  // Upper mask half is all ones exactly for a word-sized store at offset 0.
  assign req_aligned_word = bus.req_size[1] & (bus.req_addr[1:0] == 2'b00);

  always_comb begin
    data_l = data_q;
    mask_l = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        data_l = {data_q[7:0], 24'h0};
        mask_l = 32'hFF00_0000;
      end
      2'b01: begin
        data_l = {data_q[15:0], 16'h0};
        mask_l = 32'hFFFF_0000;
      end
      default: begin
        data_l = data_q;
        mask_l = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign win          = {data_l, 32'h0} >> {addr_q[1:0], 3'b000};
  assign msk          = {mask_l, 32'h0} >> {addr_q[1:0], 3'b000};
  assign w0           = addr_q[ADDR_W+1:2];
  assign w1           = w0 + ADDR_W'(1);
  assign spanning     = |msk[31:0];
  assign word_aligned = &msk[63:32];
  assign merged0      = (bus.mem_rdata & ~msk[63:32]) | (win[63:32] & msk[63:32]);
  assign merged1      = (bus.mem_rdata & ~msk[31:0])  | (win[31:0]  & msk[31:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      addr_q <= bus.req_addr[ADDR_W+1:0];
      size_q <= bus.req_size;
      data_q <= bus.req_data;
    end
  end

  // Outputs are forced quiet while rst is high so an aborted store cannot
  // issue one more RAM access in the reset cycle.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;
    if (rst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            state_nxt = req_aligned_word ? WR0 : RD0;
          end
        end
        RD0: begin
          bus.mem_addr = w0;
          bus.mem_ren  = 1'b1;
          state_nxt    = WR0;
        end
        WR0: begin
          bus.mem_addr  = w0;
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = word_aligned ? win[63:32] : merged0;
          state_nxt     = spanning ? RD1 : DONE;
        end
        RD1: begin
          bus.mem_addr = w1;
          bus.mem_ren  = 1'b1;
          state_nxt    = WR1;
        end
        WR1: begin
          bus.mem_addr  = w1;
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = merged1;
          state_nxt     = DONE;
        end
        DONE: begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unaligned_store_unit.sv
// Directed bench for unaligned_store_unit with a 1-cycle-latency RAM model
// and hand-computed expected RAM contents and latencies.
module tb_unaligned_store_unit;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  unaligned_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  unaligned_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  // Synchronous RAM: read data appears the cycle after mem_ren.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic initRam();
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'h0;
    ram[0] = 32'h1122_3344;
    ram[1] = 32'h5566_7788;
  endtask

  // Issues one request and waits (bounded) for done; lat is 0 on timeout.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] data, output int lat,
                               output bit ren_seen, output bit overlap);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_data  = data;
    @(posedge clk);
    lat      = 0;
    ren_seen = 1'b0;
    overlap  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_ren) ren_seen = 1'b1;
      if (bus.mem_ren && bus.mem_wen) overlap = 1'b1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  ren_seen, overlap, done_seen;
    int  k;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_data  = '0;
    bus.mem_rdata = '0;
    initRam();

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_done",  32'(bus.done),      32'd0);
    checkOutput("rst_ren",   32'(bus.mem_ren),   32'd0);
    checkOutput("rst_wen",   32'(bus.mem_wen),   32'd0);
    checkOutput("rst_addr",  32'(bus.mem_addr),  32'd0);
    checkOutput("rst_wdata", bus.mem_wdata,      32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Aligned word: single write, no read
    initRam();
    applyStimulus(32'h0, 2'b10, 32'hAABB_CCDD, lat, ren_seen, overlap);
    checkOutput("aw_lat", 32'(lat),      32'd2);
    checkOutput("aw_ren", 32'(ren_seen), 32'd0);
    checkOutput("aw_w0",  ram[0],        32'hAABB_CCDD);
    checkOutput("aw_w1",  ram[1],        32'h5566_7788);

    // Word at offset 1: spans two words
    initRam();
    applyStimulus(32'h1, 2'b10, 32'hAABB_CCDD, lat, ren_seen, overlap);
    checkOutput("uw_lat", 32'(lat),     32'd5);
    checkOutput("uw_ovl", 32'(overlap), 32'd0);
    checkOutput("uw_w0",  ram[0],       32'h11AA_BBCC);
    checkOutput("uw_w1",  ram[1],       32'hDD66_7788);

    // Byte at offset 2 of word 1
    initRam();
    applyStimulus(32'h6, 2'b00, 32'h0000_00EE, lat, ren_seen, overlap);
    checkOutput("b_lat", 32'(lat),      32'd3);
    checkOutput("b_ren", 32'(ren_seen), 32'd1);
    checkOutput("b_w0",  ram[0],        32'h1122_3344);
    checkOutput("b_w1",  ram[1],        32'h5566_EE88);

    // Half at offset 3: spans
    initRam();
    applyStimulus(32'h3, 2'b01, 32'h0000_BEEF, lat, ren_seen, overlap);
    checkOutput("h_lat", 32'(lat), 32'd5);
    checkOutput("h_w0",  ram[0],   32'h1122_33BE);
    checkOutput("h_w1",  ram[1],   32'hEF66_7788);

    // Wrap from the last word to word 0
    initRam();
    applyStimulus(32'hFFE, 2'b10, 32'hCAFE_F00D, lat, ren_seen, overlap);
    checkOutput("wrap_lat",  32'(lat), 32'd5);
    checkOutput("wrap_w1023", ram[1023], 32'h0000_CAFE);
    checkOutput("wrap_w0",   ram[0],    32'hF00D_3344);

    // High address bits ignored, size 11 acts as word
    initRam();
    applyStimulus(32'h8000_0004, 2'b11, 32'h0BAD_F00D, lat, ren_seen, overlap);
    checkOutput("hi_lat", 32'(lat), 32'd2);
    checkOutput("hi_w1",  ram[1],   32'h0BAD_F00D);

    // Reset during RD1 aborts the second word
    initRam();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1;
    bus.req_size  = 2'b10;
    bus.req_data  = 32'hAABB_CCDD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_in_rd1", 32'(bus.mem_ren), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mid_rst_ren",   32'(bus.mem_ren),   32'd0);
    checkOutput("mid_rst_addr",  32'(bus.mem_addr),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_ready", 32'(bus.req_ready), 32'd1);
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    checkOutput("mid_no_done", 32'(done_seen), 32'd0);
    checkOutput("mid_w0", ram[0], 32'h11AA_BBCC);
    checkOutput("mid_w1", ram[1], 32'h5566_7788);

    // Request held valid through DONE is taken only in the next IDLE
    initRam();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h6;
    bus.req_size  = 2'b00;
    bus.req_data  = 32'h0000_00EE;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 32'h8;
    bus.req_size = 2'b10;
    bus.req_data = 32'h1234_5678;
    k = 1;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("hold_lat1",  32'(k),             32'd3);
    checkOutput("hold_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("hold_idle_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.done) begin
        k = i;
        break;
      end
    end
    checkOutput("hold_lat2", 32'(k), 32'd2);
    checkOutput("hold_w1",   ram[1], 32'h5566_EE88);
    checkOutput("hold_w2",   ram[2], 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
